// File: rtl/stream_conv_packet_if.sv
// Stream bundle for stream_conv_packet: sample input, filtered packet output, size and FSM debug.
// Handshake: a beat moves on a rising edge where its valid and ready are both high; the sender holds data steady until then.
interface stream_conv_packet_if #(
  parameter int DATA_W = 8,
  parameter int SIZE_W = 12
) ();
  logic              i_tdata_valid;
  logic [DATA_W-1:0] i_tdata;
  logic              i_tdata_last;
  logic              o_tready;
  logic              i_tmanager_ready;
  logic              o_tanswer_ready;
  logic [DATA_W-1:0] o_tanswer_data;
  logic              o_tanswer_data_last;
  logic [SIZE_W-1:0] o_packet_size_in_bytes;
  logic [1:0]        state_dbg;

  modport slave (
    input  i_tdata_valid, i_tdata, i_tdata_last, i_tmanager_ready,
    output o_tready, o_tanswer_ready, o_tanswer_data, o_tanswer_data_last,
    output o_packet_size_in_bytes, state_dbg
  );

  modport master (
    output i_tdata_valid, i_tdata, i_tdata_last, i_tmanager_ready,
    input  o_tready, o_tanswer_ready, o_tanswer_data, o_tanswer_data_last,
    input  o_packet_size_in_bytes, state_dbg
  );
endinterface

// File: rtl/stream_conv_packet.sv
// Packet-buffered 3-tap stream filter (passthrough / [1,2,1]/4 smooth / edge), replicated edges.
// Optional sticky overflow output enabled by defining STREAM_CONV_OVERFLOW_FLAG_EN.
module stream_conv_packet #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int MODE   = 1,
  parameter int SIZE_W = 12
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef STREAM_CONV_OVERFLOW_FLAG_EN
  output logic o_overflow,
`endif
  stream_conv_packet_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = DATA_W + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] SEND  = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] r_a, r_b, r_c;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     rd_ptr;
  logic              pend;
  logic [SIZE_W-1:0] size_q;

  logic              in_xfer, store, out_xfer, out_last;
  logic [AW-1:0]     pend_idx, tail_idx;
  logic [DATA_W-1:0] y_pend, y_tail;

  function automatic logic [DATA_W-1:0] filt(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] c);
    logic [SW-1:0]     sum;
    logic [DATA_W-1:0] res;
    sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + SW'(2);
    res = b;
    if (MODE == 1) res = DATA_W'(sum >> 2);
    else if (MODE == 2) res = (c > a) ? (c - a) : (a - c);
    return res;
  endfunction

  assign in_xfer  = bus.i_tdata_valid && bus.o_tready;
  assign store    = in_xfer && (cnt < CW'(DEPTH));
  assign out_xfer = (state == SEND) && bus.i_tmanager_ready;
  assign out_last = (CW'(rd_ptr) == (cnt - CW'(1)));

  // r_a/r_b/r_c hold x[k-2], x[k-1], x[k] after x[k] is stored; y[k-1] is written the next cycle.
  assign pend_idx = AW'(cnt - CW'(2));
  assign tail_idx = AW'(cnt - CW'(1));
  assign y_pend   = filt(r_a, r_b, r_c);
  assign y_tail   = filt(r_b, r_c, r_c);

  assign bus.o_tready               = ((state == IDLE) || (state == RECV)) && !i_rst;
  assign bus.o_tanswer_ready        = (state == SEND);
  assign bus.o_tanswer_data         = (state == SEND) ? mem[rd_ptr] : '0;
  assign bus.o_tanswer_data_last    = (state == SEND) && out_last;
  assign bus.o_packet_size_in_bytes = size_q;
  assign bus.state_dbg              = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_ptr <= '0;
      pend   <= 1'b0;
      size_q <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
    end else begin
      pend <= store && (cnt != '0);
      if (store) begin
        // First sample also seeds x[-1] so the left edge replicates x[0].
        if (cnt == '0) begin
          r_b <= bus.i_tdata;
          r_c <= bus.i_tdata;
        end else begin
          r_a <= r_b;
          r_b <= r_c;
          r_c <= bus.i_tdata;
        end
        cnt <= cnt + CW'(1);
      end
      case (state)
        IDLE:  if (in_xfer) state <= bus.i_tdata_last ? FLUSH : RECV;
        RECV:  if (in_xfer && bus.i_tdata_last) state <= FLUSH;
        FLUSH: begin
          state  <= SEND;
          rd_ptr <= '0;
          size_q <= SIZE_W'(32'(cnt) * 32'(DATA_W / 8));
        end
        default: begin
          if (out_xfer) begin
            if (out_last) begin
              state  <= IDLE;
              cnt    <= '0;
              rd_ptr <= '0;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end
      endcase
    end
  end

  // FLUSH may carry both the pending y[N-2] and the replicated-edge y[N-1].
  always_ff @(posedge i_clk) begin
    if (pend) mem[pend_idx] <= y_pend;
    if (state == FLUSH) mem[tail_idx] <= y_tail;
  end

`ifdef STREAM_CONV_OVERFLOW_FLAG_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_overflow <= 1'b0;
    else if (in_xfer && (state == IDLE)) o_overflow <= 1'b0;
    else if (in_xfer && !store) o_overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_stream_conv_packet.sv
// Bench for stream_conv_packet: MODE 1 / DEPTH 1024 and MODE 2 / DEPTH 4 instances fed the same stream.
module tb_stream_conv_packet;
  localparam int D0 = 1024;
  localparam int D1 = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       mready;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [7:0] pkt[$];
  int         exp_size[2];
  bit         hold[2];
  logic [7:0] hold_d[2];

  always #5 clk = ~clk;

  stream_conv_packet_if #(.DATA_W(8), .SIZE_W(12)) bus0 ();
  stream_conv_packet_if #(.DATA_W(8), .SIZE_W(12)) bus1 ();

  assign bus0.i_tdata_valid    = valid;
  assign bus0.i_tdata          = data;
  assign bus0.i_tdata_last     = last;
  assign bus0.i_tmanager_ready = mready;
  assign bus1.i_tdata_valid    = valid;
  assign bus1.i_tdata          = data;
  assign bus1.i_tdata_last     = last;
  assign bus1.i_tmanager_ready = mready;

`ifdef STREAM_CONV_OVERFLOW_FLAG_EN
  logic ovf0, ovf1;
`endif

  stream_conv_packet #(.DATA_W(8), .DEPTH(D0), .MODE(1), .SIZE_W(12)) u_dut0 (
    .i_clk(clk),
    .i_rst(rst),
`ifdef STREAM_CONV_OVERFLOW_FLAG_EN
    .o_overflow(ovf0),
`endif
    .bus(bus0)
  );

  stream_conv_packet #(.DATA_W(8), .DEPTH(D1), .MODE(2), .SIZE_W(12)) u_dut1 (
    .i_clk(clk),
    .i_rst(rst),
`ifdef STREAM_CONV_OVERFLOW_FLAG_EN
    .o_overflow(ovf1),
`endif
    .bus(bus1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: MODE 1 for instance 0, MODE 2 for instance 1, with depth truncation.
  task automatic expect_pkt();
    for (int id = 0; id < 2; id++) begin
      int n, a, b, c, y, dep;
      dep = (id == 0) ? D0 : D1;
      n = pkt.size();
      if (n > dep) n = dep;
      for (int k = 0; k < n; k++) begin
        a = pkt[(k == 0) ? 0 : k - 1];
        b = pkt[k];
        c = pkt[(k == n - 1) ? k : k + 1];
        if (id == 0) y = (a + 2 * b + c + 2) / 4;
        else y = (c > a) ? (c - a) : (a - c);
        if (id == 0) exp_q0.push_back({(k == n - 1), 8'(y)});
        else exp_q1.push_back({(k == n - 1), 8'(y)});
      end
      exp_size[id] = n % 4096;
    end
  endtask

  task automatic drive_pkt(input bit with_last);
    for (int i = 0; i < pkt.size(); i++) begin
      valid = 1'b1;
      data  = pkt[i];
      last  = with_last && (i == pkt.size() - 1);
      @(negedge clk);
      check("tready0", 32'(bus0.o_tready), 32'd1);
      check("tready1", 32'(bus1.o_tready), 32'd1);
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 ||
            bus0.state_dbg != 2'd0 || bus1.state_dbg != 2'd0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_in_budget", 32'(n < 300), 32'd1);
  endtask

  task automatic mon_step(input int id, input logic v, input logic [7:0] d, input logic l);
    logic [8:0] e;
    int         qs;
    if (!v) begin
      hold[id] = 1'b0;
      return;
    end
    if (hold[id]) check($sformatf("stable%0d", id), 32'(d), 32'(hold_d[id]));
    if (mready) begin
      hold[id] = 1'b0;
      qs = (id == 0) ? exp_q0.size() : exp_q1.size();
      check($sformatf("expected_pending%0d", id), 32'(qs != 0), 32'd1);
      if (qs != 0) begin
        e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("data%0d", id), 32'(d), 32'(e[7:0]));
        check($sformatf("last%0d", id), 32'(l), 32'(e[8]));
      end
    end else begin
      hold[id]   = 1'b1;
      hold_d[id] = d;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, bus0.o_tanswer_ready, bus0.o_tanswer_data, bus0.o_tanswer_data_last);
    mon_step(1, bus1.o_tanswer_ready, bus1.o_tanswer_data, bus1.o_tanswer_data_last);
  end

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_ans_ready0"}, 32'(bus0.o_tanswer_ready), 32'd0);
    check({tag, "_ans_ready1"}, 32'(bus1.o_tanswer_ready), 32'd0);
    check({tag, "_ans_data0"}, 32'(bus0.o_tanswer_data), 32'd0);
    check({tag, "_ans_data1"}, 32'(bus1.o_tanswer_data), 32'd0);
    check({tag, "_ans_last0"}, 32'(bus0.o_tanswer_data_last), 32'd0);
    check({tag, "_ans_last1"}, 32'(bus1.o_tanswer_data_last), 32'd0);
    check({tag, "_size0"}, 32'(bus0.o_packet_size_in_bytes), 32'd0);
    check({tag, "_size1"}, 32'(bus1.o_packet_size_in_bytes), 32'd0);
    check({tag, "_state0"}, 32'(bus0.state_dbg), 32'd0);
    check({tag, "_state1"}, 32'(bus1.state_dbg), 32'd0);
  endtask

  task automatic check_sizes(input string tag);
    check({tag, "_size0"}, 32'(bus0.o_packet_size_in_bytes), 32'(exp_size[0]));
    check({tag, "_size1"}, 32'(bus1.o_packet_size_in_bytes), 32'(exp_size[1]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    int         len, n;

    // Reset state
    rst = 1'b1; valid = 1'b0; data = '0; last = 1'b0; mready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs("reset");
`ifdef STREAM_CONV_OVERFLOW_FLAG_EN
    check("reset_ovf0", 32'(ovf0), 32'd0);
    check("reset_ovf1", 32'(ovf1), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("post_reset_tready0", 32'(bus0.o_tready), 32'd1);
    check("post_reset_tready1", 32'(bus1.o_tready), 32'd1);

    // 4,8,12,16: MODE1 -> 5,8,12,15, MODE2 -> 4,8,8,4; output two cycles after last transfer
    pkt = '{8'd4, 8'd8, 8'd12, 8'd16};
    expect_pkt();
    drive_pkt(1'b1);
    check("flush_state", 32'(bus1.state_dbg), 32'd2);
    check("no_output_in_flush", 32'(bus1.o_tanswer_ready), 32'd0);
    check("tready_low_in_flush", 32'(bus1.o_tready), 32'd0);
    @(posedge clk);
    #1;
    check("output_after_2_cycles", 32'(bus1.o_tanswer_ready), 32'd1);
    wait_done();
    check_sizes("pkt_a");
    check("tready_after_send", 32'(bus0.o_tready), 32'd1);

    // Single last-flagged sample
    pkt = '{8'd200};
    expect_pkt();
    drive_pkt(1'b1);
    wait_done();
    check_sizes("single");

    // Over-depth packet 1..6 (instance 1 keeps 4)
    pkt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    expect_pkt();
    drive_pkt(1'b1);
    wait_done();
    check_sizes("overflow");
`ifdef STREAM_CONV_OVERFLOW_FLAG_EN
    check("ovf_set1", 32'(ovf1), 32'd1);
    check("ovf_clear0", 32'(ovf0), 32'd0);
`endif

    // Downstream stalls 1,0,0,1 during SEND
    pkt = '{8'd30, 8'd60, 8'd90, 8'd120};
    expect_pkt();
    drive_pkt(1'b1);
    n = 0;
    while (!bus0.o_tanswer_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("send_reached", 32'(bus0.o_tanswer_ready), 32'd1);
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      mready = pat[3 - i];
      @(posedge clk);
      #1;
    end
    mready = 1'b1;
    wait_done();
    check_sizes("stall");
`ifdef STREAM_CONV_OVERFLOW_FLAG_EN
    check("ovf_cleared1", 32'(ovf1), 32'd0);
`endif

    // Reset after the 2nd sample of a packet: nothing may come out of it
    pkt = '{8'd77, 8'd88};
    drive_pkt(1'b0);
    rst = 1'b1;
    #1;
    check_quiet_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_reset_tready0", 32'(bus0.o_tready), 32'd1);
    check("mid_reset_tready1", 32'(bus1.o_tready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_reset_no_output", 32'(bus0.o_tanswer_ready), 32'd0);
    pkt = '{8'd10, 8'd10};
    expect_pkt();
    drive_pkt(1'b1);
    wait_done();
    check_sizes("after_reset");

    // Random packet
    len = $urandom_range(3, 7);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
    expect_pkt();
    drive_pkt(1'b1);
    wait_done();
    check_sizes("random");
`ifdef STREAM_CONV_OVERFLOW_FLAG_EN
    check("random_ovf1", 32'(ovf1), 32'(len > D1));
`endif

    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_conv_packet.md
STREAM_CONV_PACKET -- requirements
Module: stream_conv_packet

Interface
REQ-001 Parameter DATA_W, default 8: sample width in bits; a multiple of 8.
REQ-002 Parameter DEPTH, default 1024: maximum samples buffered per packet.
REQ-003 Parameter MODE, default 1: 0 = passthrough, 1 = [1,2,1]/4 smoothing, 2 = edge |x[n+1]-x[n-1]|.
REQ-004 Parameter SIZE_W, default 12: width of the packet-size output.
REQ-005 Ports, one per line:
- i_clk  in  1  sole clock; all logic on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_tdata_valid  in  1  input sample valid.
- i_tdata  in  DATA_W  input sample.
- i_tdata_last  in  1  marks the final sample of a packet.
- o_tready  out  1  block accepts input.
- i_tmanager_ready  in  1  downstream accepts output.
- o_tanswer_ready  out  1  output sample valid.
- o_tanswer_data  out  DATA_W  output sample.
- o_tanswer_data_last  out  1  marks the final output sample.
- o_packet_size_in_bytes  out  SIZE_W  stored samples x DATA_W/8.

Function
REQ-006 The FSM SHALL have states IDLE, RECV, FLUSH and SEND.
REQ-007 An input transfer SHALL occur when i_tdata_valid and o_tready are both high; o_tready SHALL be high only in IDLE and RECV.
REQ-008 IDLE SHALL go to RECV on the first transfer, and RECV SHALL go to FLUSH on the transfer carrying i_tdata_last.
REQ-009 FLUSH SHALL last exactly one cycle and then go to SEND.
REQ-010 Output sample y[n] SHALL be computed and written to the packet buffer in the cycle after x[n+1] is accepted; y[last] SHALL be written in FLUSH.
REQ-011 At packet edges x[-1] SHALL equal x[0] and x[N] SHALL equal x[N-1] (replication).
REQ-012 MODE 1 SHALL compute (a+2b+c+2)>>2 with DATA_W+2-bit intermediates; the result fits without saturation.
REQ-013 MODE 2 SHALL compute |c-a| as unsigned, where a = x[n-1] and c = x[n+1].
REQ-014 MODE 0 SHALL output y[n] = x[n].
REQ-015 Samples beyond DEPTH SHALL be accepted and discarded (not written); i_tdata_last SHALL still end the packet.
REQ-016 o_packet_size_in_bytes SHALL update on entry to SEND to stored_count*(DATA_W/8), truncated to SIZE_W bits, and hold until the next SEND.
REQ-017 In SEND:
- o_tanswer_ready SHALL be high and o_tanswer_data SHALL present buffer[rd_ptr].
- A transfer SHALL occur when i_tmanager_ready is high; rd_ptr SHALL then advance.
- o_tanswer_data SHALL hold steady while i_tmanager_ready is low.
REQ-018 o_tanswer_data_last SHALL be high with the final stored sample; its transfer SHALL return the FSM to IDLE, with o_tready high in the next cycle.
REQ-019 i_tdata_valid in FLUSH or SEND SHALL be ignored, since no transfer occurs with o_tready low.
REQ-020 A last-flagged first sample (N = 1) SHALL produce one output sample: x in MODE 0/1, 0 in MODE 2.

Reset
REQ-021 While i_rst is high:
- All outputs SHALL be 0, except o_tready, which SHALL be 1 after reset releases.
- The FSM SHALL be in IDLE and the pointers SHALL be 0.
REQ-022 Reset asserted mid-packet or mid-SEND SHALL discard the packet immediately, with no partial output after release.
REQ-023 Buffer contents SHALL NOT require reset.

Configuration
REQ-024 With STREAM_CONV_OVERFLOW_FLAG_EN defined:
- Output o_overflow (1 bit) SHALL exist.
- It SHALL be set when a sample is discarded per REQ-015.
- It SHALL be sticky until the next packet's first transfer or reset.
REQ-025 With STREAM_CONV_OVERFLOW_FLAG_EN undefined, the port and its logic SHALL be absent; discard behaviour SHALL be unchanged.

Verification
REQ-026 MODE 1, packet 4,8,12,16 (last on 16), manager ready always -> outputs 5,8,12,15; last on 15; size = 4.
REQ-027 MODE 2, same packet -> outputs 4,8,8,4; o_tanswer_ready first high 2 cycles after the last input transfer.
REQ-028 MODE 1, single sample 200 with last -> one output 200 with last high; size = 1.
REQ-029 DEPTH = 4, 6-sample packet 1..6 -> exactly 4 outputs, derived from x = 1,2,3,4 with x[4] replicated; size = 4; o_overflow = 1 when enabled.
REQ-030 i_tmanager_ready toggled 1,0,0,1 during SEND -> data stable across stalls, no sample lost or duplicated.
REQ-031 i_rst pulsed after the 2nd input sample -> all outputs 0, o_tready 1 after release; the following packet 10,10 in MODE 1 -> 10,10.
